key_search_ctrl: RTL and testbench

//  Parametrised key-search sequencer for the DES code breaker. Issues LANES consecutive

---
 rtl/key_search_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_key_search_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// Key-search sequencer for the DES code breaker: issues LANES candidate keys per cycle,
// tracks each issue through the core pipeline and reports the lowest matching key.
module key_search_ctrl #(
  parameter int KEY_W    = 56,
  parameter int LANES    = 4,
  parameter int PIPE_LAT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [KEY_W-1:0]   key_lo,
  input  logic [KEY_W-1:0]   key_hi,
  input  logic [LANES-1:0]   lane_match,
  output logic               issue_valid,
  output logic [KEY_W-1:0]   issue_base,
  output logic [LANES-1:0]   issue_mask,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic               done,
  output logic [KEY_W-1:0]   key_out,
  output logic [KEY_W:0]     keys_tried
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = KEY_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_FOUND   = 3'd3,
    S_EXHAUST = 3'd4
  } state_t;

  // Lane i is enabled iff base+i <= hi, compared one bit wider so the top of the range cannot wrap.
  function automatic logic [LANES-1:0] lane_mask(input logic [KEY_W-1:0] base,
                                                 input logic [KEY_W-1:0] hi);
    logic [LANES-1:0] m;
    m = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      m[i] = (({1'b0, base} + CNT_W'(i)) <= {1'b0, hi});
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] m);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [LANES-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = LANES - 1; i >= 0; i--) begin
      idx = m[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  state_t             state_r, state_s;
  logic [KEY_W-1:0]   hi_r;
  logic               issue_valid_r, nxt_valid_s;
  logic [KEY_W-1:0]   issue_base_r, nxt_base_s;
  logic [LANES-1:0]   issue_mask_r, nxt_mask_s;
  logic               busy_r, found_r, exhausted_r, done_r;
  logic [KEY_W-1:0]   key_out_r;
  logic [CNT_W-1:0]   keys_tried_r;

  logic               tag_valid_r [PIPE_LAT];
  logic [KEY_W-1:0]   tag_base_r  [PIPE_LAT];
  logic [LANES-1:0]   tag_mask_r  [PIPE_LAT];

  logic [LANES-1:0]   hit_vec_s;
  logic               hit_s;
  logic [KEY_W-1:0]   hit_key_s;
  logic               inflight_s;
  logic               last_s;
  logic [KEY_W-1:0]   step_base_s;
  logic               load_s, capture_s, flush_s;

  // Match detection on the tag stage aligned with lane_match.
  always_comb begin
    hit_vec_s = lane_match & tag_mask_r[PIPE_LAT-1];
    hit_s     = tag_valid_r[PIPE_LAT-1] & (|hit_vec_s);
    hit_key_s = tag_base_r[PIPE_LAT-1] + KEY_W'(lowest_idx(hit_vec_s));
  end

  // Issues still in flight once the final stage retires this cycle.
  always_comb begin
    inflight_s = 1'b0;
    for (int k = 0; k < PIPE_LAT - 1; k++) begin
      inflight_s = inflight_s | tag_valid_r[k];
    end
  end

  // Range step for the issue currently on the outputs.
  always_comb begin
    last_s      = (({1'b0, issue_base_r} + CNT_W'(LANES)) > {1'b0, hi_r});
    step_base_s = issue_base_r + KEY_W'(LANES);
  end

  // Next-state and next-issue decode.
  always_comb begin
    state_s     = state_r;
    nxt_valid_s = 1'b0;
    nxt_base_s  = issue_base_r;
    nxt_mask_s  = {LANES{1'b0}};
    load_s      = 1'b0;
    capture_s   = 1'b0;
    flush_s     = 1'b0;
    if (abort) begin
      state_s = S_IDLE;
      flush_s = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            load_s = 1'b1;
            if (key_lo > key_hi) begin
              state_s = S_EXHAUST;
            end else begin
              state_s     = S_ISSUE;
              nxt_valid_s = 1'b1;
              nxt_base_s  = key_lo;
              nxt_mask_s  = lane_mask(key_lo, key_hi);
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_ISSUE: begin
          if (hit_s) begin
            state_s   = S_FOUND;
            capture_s = 1'b1;
            flush_s   = 1'b1;
          end else if (last_s) begin
            state_s = S_DRAIN;
          end else begin
            state_s     = S_ISSUE;
            nxt_valid_s = 1'b1;
            nxt_base_s  = step_base_s;
            nxt_mask_s  = lane_mask(step_base_s, hi_r);
          end
        end
        S_DRAIN: begin
          if (hit_s) begin
            state_s   = S_FOUND;
            capture_s = 1'b1;
            flush_s   = 1'b1;
          end else if (!inflight_s) begin
            state_s = S_EXHAUST;
          end else begin
            state_s = S_DRAIN;
          end
        end
        S_FOUND, S_EXHAUST: begin
          if (!start) begin
            state_s = S_IDLE;
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s = S_IDLE;
          flush_s = 1'b1;
        end
      endcase
    end
  end

  // State, issue outputs and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      issue_valid_r <= 1'b0;
      issue_base_r  <= {KEY_W{1'b0}};
      issue_mask_r  <= {LANES{1'b0}};
      busy_r        <= 1'b0;
      found_r       <= 1'b0;
      exhausted_r   <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      issue_valid_r <= nxt_valid_s;
      issue_base_r  <= nxt_base_s;
      issue_mask_r  <= nxt_mask_s;
      busy_r        <= (state_s == S_ISSUE) || (state_s == S_DRAIN);
      found_r       <= (state_s == S_FOUND);
      exhausted_r   <= (state_s == S_EXHAUST);
      done_r        <= (state_s == S_FOUND) || (state_s == S_EXHAUST);
    end
  end

  // Search range, result key and issued-key counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r         <= {KEY_W{1'b0}};
      key_out_r    <= {KEY_W{1'b0}};
      keys_tried_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      hi_r         <= key_hi;
      key_out_r    <= {KEY_W{1'b0}};
      keys_tried_r <= {CNT_W{1'b0}};
    end else begin
      hi_r         <= hi_r;
      key_out_r    <= capture_s ? hit_key_s : key_out_r;
      keys_tried_r <= (issue_valid_r && !abort) ? keys_tried_r + popcount(issue_mask_r)
                                                : keys_tried_r;
    end
  end

  // Tag pipe mirroring the DES core latency; a flush kills every in-flight issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_valid_r[k] <= 1'b0;
        tag_base_r[k]  <= {KEY_W{1'b0}};
        tag_mask_r[k]  <= {LANES{1'b0}};
      end
    end else begin
      tag_valid_r[0] <= issue_valid_r & ~flush_s;
      tag_base_r[0]  <= issue_base_r;
      tag_mask_r[0]  <= issue_mask_r;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_valid_r[k] <= tag_valid_r[k-1] & ~flush_s;
        tag_base_r[k]  <= tag_base_r[k-1];
        tag_mask_r[k]  <= tag_mask_r[k-1];
      end
    end
  end

  assign issue_valid = issue_valid_r;
  assign issue_base  = issue_base_r;
  assign issue_mask  = issue_mask_r;
  assign busy        = busy_r;
  assign found       = found_r;
  assign exhausted   = exhausted_r;
  assign done        = done_r;
  assign key_out     = key_out_r;
  assign keys_tried  = keys_tried_r;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl (KEY_W=8, LANES=4, PIPE_LAT=3) with a core-latency responder.
module tb_key_search_ctrl;

  localparam int KW = 8;
  localparam int LN = 4;
  localparam int PL = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [KW-1:0] key_lo;
  logic [KW-1:0] key_hi;
  logic [LN-1:0] lane_match;
  logic          issue_valid;
  logic [KW-1:0] issue_base;
  logic [LN-1:0] issue_mask;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic          done;
  logic [KW-1:0] key_out;
  logic [KW:0]   keys_tried;

  key_search_ctrl #(.KEY_W(KW), .LANES(LN), .PIPE_LAT(PL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .key_lo     (key_lo),
    .key_hi     (key_hi),
    .lane_match (lane_match),
    .issue_valid(issue_valid),
    .issue_base (issue_base),
    .issue_mask (issue_mask),
    .busy       (busy),
    .found      (found),
    .exhausted  (exhausted),
    .done       (done),
    .key_out    (key_out),
    .keys_tried (keys_tried)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] lo;
    logic [KW-1:0] hi;
    logic [KW-1:0] tgt_base;
    logic [LN-1:0] tgt_vec;
    logic          exp_found;
    logic [KW-1:0] exp_key;
    logic [KW:0]   exp_tried;
    int            exp_issues;
    logic [LN-1:0] exp_first_mask;
    logic [KW-1:0] exp_last_base;
    logic [LN-1:0] exp_last_mask;
    int            exp_done_cyc;
  } vec_t;

  vec_t          vecs [8];
  int            n_cmp;
  int            n_err;
  int            cyc;
  logic [KW-1:0] tgt_base;
  logic [LN-1:0] tgt_vec;
  logic [LN-1:0] resp_pipe [PL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_resp();
    for (int k = 0; k < PL; k++) resp_pipe[k] = '0;
    lane_match = '0;
  endtask

  // One clock; the responder answers a target issue PL cycles after it appears.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    lane_match = resp_pipe[PL-1];
    for (int k = PL - 1; k > 0; k--) resp_pipe[k] = resp_pipe[k-1];
    resp_pipe[0] = (issue_valid && issue_base == tgt_base) ? tgt_vec : 4'b0000;
  endtask

  task automatic run_vec(input int i);
    vec_t          v;
    int            issues;
    int            first_cyc;
    int            done_cyc;
    int            t;
    logic          got_done;
    logic [KW-1:0] last_base;
    logic [LN-1:0] last_mask;
    v = vecs[i];
    tgt_base = v.tgt_base;
    tgt_vec  = v.tgt_vec;
    clear_resp();
    key_lo = v.lo;
    key_hi = v.hi;
    start  = 1'b1;
    cyc = 0; issues = 0; first_cyc = 0; done_cyc = 0; t = 0;
    got_done = 1'b0; last_base = '0; last_mask = '0;
    while (!got_done && t < 64) begin
      t++;
      tick();
      if (issue_valid) begin
        issues++;
        check("base_seq", issue_base, v.lo + 8'(4 * (issues - 1)));
        if (issues == 1) begin
          first_cyc = cyc;
          check("first_mask", issue_mask, v.exp_first_mask);
        end
        last_base = issue_base;
        last_mask = issue_mask;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_seen", got_done, 1'b1);
    check("done_cycle", done_cyc, v.exp_done_cyc);
    check("found", found, v.exp_found);
    check("exhausted", exhausted, !v.exp_found);
    check("busy_at_done", busy, 1'b0);
    check("keys_tried", keys_tried, v.exp_tried);
    check("issue_count", issues, v.exp_issues);
    if (v.exp_found) check("key_out", key_out, v.exp_key);
    if (v.exp_issues > 0) begin
      check("first_issue_cycle", first_cyc, 1);
      check("last_base", last_base, v.exp_last_base);
      check("last_mask", last_mask, v.exp_last_mask);
    end
    start = 1'b0;
    tick();
    check("idle_done", done, 1'b0);
    check("idle_found", found, 1'b0);
    check("idle_tried_hold", keys_tried, v.exp_tried);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    tgt_base = '0; tgt_vec = '0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; key_lo = '0; key_hi = '0;
    clear_resp();

    //          lo     hi     tgt    vec      f     key    tried  n  fmask    lbase  lmask    dc
    vecs[0] = '{8'h10, 8'h1F, 8'h14, 4'b0100, 1'b1, 8'h16, 9'd16, 4, 4'b1111, 8'h1C, 4'b1111, 6};
    vecs[1] = '{8'h00, 8'h05, 8'h00, 4'b0000, 1'b0, 8'h00, 9'd6,  2, 4'b1111, 8'h04, 4'b0011, 6};
    vecs[2] = '{8'h40, 8'h4F, 8'h44, 4'b1010, 1'b1, 8'h45, 9'd16, 4, 4'b1111, 8'h4C, 4'b1111, 6};
    vecs[3] = '{8'hFC, 8'hFF, 8'h00, 4'b0000, 1'b0, 8'h00, 9'd4,  1, 4'b1111, 8'hFC, 4'b1111, 5};
    vecs[4] = '{8'h20, 8'h10, 8'h00, 4'b0000, 1'b0, 8'h00, 9'd0,  0, 4'b0000, 8'h00, 4'b0000, 1};
    vecs[5] = '{8'h33, 8'h33, 8'h33, 4'b0001, 1'b1, 8'h33, 9'd1,  1, 4'b0001, 8'h33, 4'b0001, 5};
    vecs[6] = '{8'hF8, 8'hFF, 8'hFC, 4'b1000, 1'b1, 8'hFF, 9'd8,  2, 4'b1111, 8'hFC, 4'b1111, 6};
    vecs[7] = '{8'h00, 8'h05, 8'h04, 4'b0100, 1'b0, 8'h00, 9'd6,  2, 4'b1111, 8'h04, 4'b0011, 6};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_found", found, 1'b0);
    check("rst_exhausted", exhausted, 1'b0);
    check("rst_key_out", key_out, 8'h00);
    check("rst_keys_tried", keys_tried, 9'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i);

    // abort mid-ISSUE; the pending match for base 0x04 must be ignored
    tgt_base = 8'h04; tgt_vec = 4'b0001;
    clear_resp();
    key_lo = 8'h00; key_hi = 8'h3F; start = 1'b1;
    tick();
    tick();
    check("abort_pre_issue", issue_valid, 1'b1);
    check("abort_pre_base", issue_base, 8'h04);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_issue_valid", issue_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("abort_no_found", found, 1'b0);
      check("abort_no_issue", issue_valid, 1'b0);
    end

    // reset pulsed while draining
    tgt_base = 8'h00; tgt_vec = 4'b0000;
    clear_resp();
    key_lo = 8'h00; key_hi = 8'h05; start = 1'b1;
    tick();
    tick();
    tick();
    check("drain_busy", busy, 1'b1);
    check("drain_no_issue", issue_valid, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_issue_base", issue_base, 8'h00);
    check("mid_rst_issue_mask", issue_mask, 4'b0000);
    check("mid_rst_keys_tried", keys_tried, 9'd0);
    check("mid_rst_done", done, 1'b0);
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    clear_resp();
    tick();
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
